hbm_rd_stream: RTL

Read-side engine on an HBM AXI port. It accepts a read command (start address and beat count) and issues AXI4 INCR read bursts toward the HBM controller. Returned data is forwarded as an AXI4-Stream with `tlast` on the final beat. It complements the QDMA host-to-card write path: the design uses it to pull HBM contents back out toward the card-to-host side.

---
 rtl/hbm_rd_stream.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hbm_rd_stream.sv
// hbm_rd_stream: splits a read command into 4 KB-safe AXI4 INCR bursts and forwards R data as AXI4-Stream.
module hbm_rd_stream #(
   parameter int ADDR_W          = 33,
   parameter int DATA_W          = 256,
   parameter int LEN_W           = 20,
   parameter int MAX_BURST       = 16,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_beats,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [7:0]        m_axi_arlen,
   output logic [2:0]        m_axi_arsize,
   output logic [1:0]        m_axi_arburst,
   output logic [5:0]        m_axi_arid,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tlast,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t             r_state;
   logic               r_cmd_ready, r_arvalid, r_err, r_done, r_busy;
   logic [ADDR_W-1:0]  r_araddr;
   logic [7:0]         r_arlen;
   logic [LEN_W-1:0]   r_ar_left, r_data_left;
   logic [OUT_W-1:0]   r_out;
   logic               w_cmd_hs, w_ar_hs, w_r_hs, w_rl_hs, w_unused;
   logic [OUT_W-1:0]   w_out_next;
   logic [LEN_W-1:0]   w_left_next, w_ar_left_next;
   logic [ADDR_W-1:0]  w_cmd_addr, w_addr_next;
   logic [8:0]         w_cur, w_first, w_next;

   // beats to the next 4 KB page are 128 - addr[11:5]
   function automatic logic [8:0] f_burst(input logic [6:0] pg, input logic [LEN_W-1:0] l);
      logic [8:0] p;
      p = 9'd128 - {2'b00, pg};
      if (9'(MAX_BURST) < p) p = 9'(MAX_BURST);
      return (l < LEN_W'(p)) ? l[8:0] : p;
   endfunction

   always_comb begin
      w_cmd_hs       = cmd_valid & r_cmd_ready;
      w_ar_hs        = r_arvalid & m_axi_arready;
      w_r_hs         = m_axi_rvalid & m_axi_rready;
      w_rl_hs        = w_r_hs & m_axi_rlast;
      w_out_next     = r_out + OUT_W'(w_ar_hs) - OUT_W'(w_rl_hs);
      w_left_next    = r_data_left - LEN_W'(w_r_hs);
      w_cur          = {1'b0, r_arlen} + 9'd1;
      w_cmd_addr     = {cmd_addr[ADDR_W-1:5], 5'b0};
      w_addr_next    = r_araddr + ADDR_W'({w_cur, 5'b0});
      w_ar_left_next = r_ar_left - LEN_W'(w_cur);
      w_first        = f_burst(w_cmd_addr[11:5], cmd_beats);
      w_next         = f_burst(w_addr_next[11:5], w_ar_left_next);
   end

   assign w_unused      = ^{cmd_addr[4:0], m_axi_rresp[0]};
   assign cmd_ready     = r_cmd_ready;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arlen   = r_arlen;
   assign m_axi_arsize  = 3'b101;
   assign m_axi_arburst = 2'b01;
   assign m_axi_arid    = 6'd0;
   assign m_axi_rready  = m_axis_tready & (r_state != IDLE);
   assign m_axis_tvalid = m_axi_rvalid & (r_state != IDLE);
   assign m_axis_tdata  = m_axi_rdata;
   assign m_axis_tlast  = (r_data_left == LEN_W'(1));
   assign busy          = r_busy;
   assign done          = r_done;
   assign err           = r_err;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state     <= IDLE;
         r_cmd_ready <= 1'b0;
         r_arvalid   <= 1'b0;
         r_araddr    <= '0;
         r_arlen     <= '0;
         r_ar_left   <= '0;
         r_data_left <= '0;
         r_out       <= '0;
         r_err       <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_out       <= w_out_next;
         r_data_left <= w_left_next;
         if (w_r_hs & m_axi_rresp[1]) r_err <= 1'b1;
         case (r_state)
            IDLE: begin
               r_cmd_ready <= ~w_cmd_hs;
               if (w_cmd_hs) begin
                  r_err <= 1'b0;
                  if (cmd_beats == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state     <= ISSUE;
                     r_busy      <= 1'b1;
                     r_arvalid   <= 1'b1;
                     r_araddr    <= w_cmd_addr;
                     r_arlen     <= 8'(w_first - 9'd1);
                     r_ar_left   <= cmd_beats;
                     r_data_left <= cmd_beats;
                  end
               end
            end
            ISSUE: begin
               if (w_ar_hs) begin
                  r_araddr  <= w_addr_next;
                  r_ar_left <= w_ar_left_next;
                  if (w_ar_left_next == '0) begin
                     r_state   <= DRAIN;
                     r_arvalid <= 1'b0;
                  end else begin
                     r_arlen   <= 8'(w_next - 9'd1);
                     r_arvalid <= w_out_next < OUT_W'(MAX_OUTSTANDING);
                  end
               end else if (!r_arvalid) r_arvalid <= w_out_next < OUT_W'(MAX_OUTSTANDING);
            end
            DRAIN: begin
               if (w_left_next == '0 && w_out_next == '0) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            DONE: begin
               r_state     <= IDLE;
               r_cmd_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule
